// File: rtl/tt_pkg.sv
// Shared types and helpers for the programmable truth table.
// Optional feature macro: TT_PARITY_EN (parity storage and checking).
package tt_pkg;

  // Controller states: power-on clear, idle service, full-table sweep.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2
  } tt_state_e;

  // Even-parity bit of a zero-extended value: 1 when the value has an odd
  // number of ones, so that value plus this bit carries an even count.
  function automatic logic tt_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/prog_truthtable_if.sv
// Lookup/write/sweep bus of the programmable truth table.
// Optional feature macro: TT_PARITY_EN adds wr_par_flip and parity_err.
interface prog_truthtable_if #(
  parameter int A_W = 3,
  parameter int B_W = 4,
  parameter int Y_W = 3
);
  localparam int IW = A_W + B_W + 1;

  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           x;
  logic           in_valid;
  logic           ready;
  logic           wr_en;
  logic [IW-1:0]  wr_addr;
  logic [Y_W-1:0] wr_data;
  logic           sweep_start;
  logic [Y_W-1:0] y;
  logic           y_valid;
  logic [IW-1:0]  sweep_idx;
  logic           sweep_done;
`ifdef TT_PARITY_EN
  logic           wr_par_flip;
  logic           parity_err;
`endif

  // Requester side (bench or host logic).
  modport master (
    output a, b, x, in_valid, wr_en, wr_addr, wr_data, sweep_start,
`ifdef TT_PARITY_EN
    output wr_par_flip,
    input  parity_err,
`endif
    input  ready, y, y_valid, sweep_idx, sweep_done
  );

  // Truth-table side.
  modport slave (
    input  a, b, x, in_valid, wr_en, wr_addr, wr_data, sweep_start,
`ifdef TT_PARITY_EN
    input  wr_par_flip,
    output parity_err,
`endif
    output ready, y, y_valid, sweep_idx, sweep_done
  );

endinterface

// File: rtl/tt_mem.sv
// Table storage: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new
// data (write-first). Only the read register is reset; the array is not.
module tt_mem #(
  parameter int AW = 8,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int N = 2 ** AW;

  logic [DW-1:0] mem_q [N];

  // Array write; contents survive reset and are only changed by writes.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Registered read with write-first bypass; holds when not reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      if (we && (waddr == raddr)) begin
        rdata <= wdata;
      end else begin
        rdata <= mem_q[raddr];
      end
    end
  end

endmodule

// File: rtl/prog_truthtable.sv
// Programmable registered truth table: y = table[{a, b, x}].
// Power-on clear, single lookups, run-time writes and a full-table sweep.
// Optional feature macro: TT_PARITY_EN (per-entry even parity, flip-on-write
// for fault injection, parity_err flag alongside y_valid).
//
// state | meaning
// ------+-----------------------------------------------------------
// CLEAR | write DEFAULT_Y to entry cnt, one entry per cycle, 0..N-1
// IDLE  | ready=1: accept lookups, writes and sweep_start
// SWEEP | read entry cnt, one per cycle, 0..N-1, onto y/sweep_idx
module prog_truthtable
  import tt_pkg::*;
#(
  parameter int             A_W       = 3,
  parameter int             B_W       = 4,
  parameter int             Y_W       = 3,
  parameter logic [Y_W-1:0] DEFAULT_Y = '0
) (
  input  logic       clk,
  input  logic       rst,
  prog_truthtable_if.slave bus
);
  localparam int IW = A_W + B_W + 1;
`ifdef TT_PARITY_EN
  localparam int DW = Y_W + 1;
`else
  localparam int DW = Y_W;
`endif

  localparam logic [IW-1:0] LAST_IDX = {IW{1'b1}};

  tt_state_e     state_q, state_nxt;
  logic [IW-1:0] cnt_q, cnt_nxt;
  logic          ready_q;
  logic          y_valid_q;
  logic [IW-1:0] sweep_idx_q;
  logic          sweep_done_q;

  logic [IW-1:0] lookup_idx;
  logic          cnt_last;
  logic          sweep_rd;

  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [IW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] wr_word;
  logic [DW-1:0] clr_word;

  assign lookup_idx = {bus.a, bus.b, bus.x};
  assign cnt_last   = (cnt_q == LAST_IDX);

`ifdef TT_PARITY_EN
  assign wr_word  = {tt_parity(32'(bus.wr_data)) ^ bus.wr_par_flip, bus.wr_data};
  assign clr_word = {tt_parity(32'(DEFAULT_Y)), DEFAULT_Y};
`else
  assign wr_word  = bus.wr_data;
  assign clr_word = DEFAULT_Y;
`endif

  // State and shared clear/sweep index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state, index advance and table port steering.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = wr_word;
    mem_re    = 1'b0;
    mem_raddr = lookup_idx;
    sweep_rd  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = clr_word;
        cnt_nxt   = cnt_q + 1'b1;
        if (cnt_last) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        mem_we = bus.wr_en;
        mem_re = bus.in_valid;
        if (bus.sweep_start) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        mem_re    = 1'b1;
        mem_raddr = cnt_q;
        sweep_rd  = 1'b1;
        cnt_nxt   = cnt_q + 1'b1;
        if (cnt_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Handshake and output qualifiers, aligned with the registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q      <= 1'b0;
      y_valid_q    <= 1'b0;
      sweep_idx_q  <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      ready_q      <= (state_nxt == IDLE);
      y_valid_q    <= mem_re;
      sweep_done_q <= sweep_rd && cnt_last;
      if (sweep_rd) begin
        sweep_idx_q <= cnt_q;
      end
    end
  end

  tt_mem #(
    .AW(IW),
    .DW(DW)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re),
    .raddr(mem_raddr),
    .rdata(mem_rdata)
  );

  assign bus.ready      = ready_q;
  assign bus.y          = mem_rdata[Y_W-1:0];
  assign bus.y_valid    = y_valid_q;
  assign bus.sweep_idx  = sweep_idx_q;
  assign bus.sweep_done = sweep_done_q;

`ifdef TT_PARITY_EN
  assign bus.parity_err = y_valid_q &
                          (tt_parity(32'(mem_rdata[Y_W-1:0])) ^ mem_rdata[Y_W]);
`endif

endmodule

// File: tb/tb_prog_truthtable.sv
// Bench for prog_truthtable: cycle-indexed reference model plus directed
// vectors with literal expectations. Optional macro: TT_PARITY_EN.
module tb_prog_truthtable;
  localparam int N = 256;

  logic clk;
  logic rst;

  prog_truthtable_if #(.A_W(3), .B_W(4), .Y_W(3)) bus ();

  prog_truthtable #(
    .A_W(3), .B_W(4), .Y_W(3), .DEFAULT_Y(3'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle c is the interval after the c-th rising edge.
  // Ready and sweep windows come straight from the cycle offsets.
  int       cyc = 0;
  int       clear_start = 0;
  int       sweep_t = -1;
  bit       armed = 0;
  logic [2:0] m_tab [N];
  bit       m_flip [N];
  logic [2:0] exp_y = '0;
  bit       exp_valid = 0;
  bit       exp_done = 0;
  bit       exp_sweep = 0;
  bit       exp_perr = 0;
  bit       exp_ready = 0;
  int       exp_idx = 0;

  function automatic bit m_ready(input int c);
    if (!armed) return 1'b0;
    if (c < clear_start + N) return 1'b0;
    if (sweep_t >= 0 && c >= sweep_t + 1 && c <= sweep_t + N) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int idx;
    int k;
    bit rdy;
    if (rst) begin
      armed       = 1;
      clear_start = cyc + 1;
      sweep_t     = -1;
      for (int i = 0; i < N; i++) begin
        m_tab[i]  = 3'd0;
        m_flip[i] = 1'b0;
      end
      exp_y = '0; exp_valid = 0; exp_done = 0; exp_sweep = 0; exp_perr = 0;
    end else if (armed) begin
      rdy = m_ready(cyc);
      exp_valid = 0; exp_done = 0; exp_sweep = 0; exp_perr = 0;
      idx = int'({bus.a, bus.b, bus.x});
      if (rdy && bus.wr_en) begin
        m_tab[bus.wr_addr] = bus.wr_data;
`ifdef TT_PARITY_EN
        m_flip[bus.wr_addr] = bus.wr_par_flip;
`else
        m_flip[bus.wr_addr] = 1'b0;
`endif
      end
      if (rdy && bus.in_valid) begin
        exp_valid = 1;
        exp_y     = m_tab[idx];
        exp_perr  = m_flip[idx];
      end
      if (rdy && bus.sweep_start) sweep_t = cyc;
      if (sweep_t >= 0 && cyc + 1 >= sweep_t + 2 && cyc + 1 <= sweep_t + 1 + N) begin
        k = cyc + 1 - sweep_t - 2;
        exp_valid = 1;
        exp_sweep = 1;
        exp_y     = m_tab[k];
        exp_perr  = m_flip[k];
        exp_idx   = k;
        exp_done  = (k == N - 1);
      end
    end
    cyc++;
    exp_ready = m_ready(cyc);
  end

  // Compare process: every cycle once the model is armed by a reset edge.
  always @(negedge clk) begin
    if (armed) begin
      check("ready", int'(bus.ready), int'(exp_ready));
      check("y_valid", int'(bus.y_valid), int'(exp_valid));
      check("y", int'(bus.y), int'(exp_y));
      check("sweep_done", int'(bus.sweep_done), int'(exp_done));
      if (exp_sweep) check("sweep_idx", int'(bus.sweep_idx), exp_idx);
`ifdef TT_PARITY_EN
      check("parity_err", int'(bus.parity_err), int'(exp_valid && exp_perr));
`endif
    end
  end

  task automatic set_idx(input logic [7:0] idx);
    bus.a = idx[7:5];
    bus.b = idx[4:1];
    bus.x = idx[0];
  endtask

  // One-cycle lookup; returns at the negedge of the result cycle.
  task automatic lookup(input logic [7:0] idx);
    set_idx(idx);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic write(input logic [7:0] addr, input logic [2:0] data, input bit flip);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
`ifdef TT_PARITY_EN
    bus.wr_par_flip = flip;
`else
    if (flip) $display("note: parity flip requested without parity build");
`endif
    @(negedge clk);
    bus.wr_en = 1'b0;
`ifdef TT_PARITY_EN
    bus.wr_par_flip = 1'b0;
`endif
  endtask

  // Counts cycles with ready low, starting at the current negedge.
  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!bus.ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 256);
  endtask

  function automatic int sweep_lit(input int k);
    case (k)
      8'h08:   return 1;
      8'hE5:   return 2;
      8'h82:   return 3;
      default: return 0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.a = '0; bus.b = '0; bus.x = 1'b0; bus.in_valid = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.sweep_start = 1'b0;
`ifdef TT_PARITY_EN
    bus.wr_par_flip = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.ready), 0);
    check("rst_y_valid", int'(bus.y_valid), 0);
    check("rst_y", int'(bus.y), 0);
    rst = 1'b0;
    count_clear("clear_len_poweron");

    lookup(8'hE5);
    check("lk_cleared_valid", int'(bus.y_valid), 1);
    check("lk_cleared_y", int'(bus.y), 0);

    write(8'hE5, 3'd2, 1'b0);
    lookup(8'hE5);
    check("lk_e5_valid", int'(bus.y_valid), 1);
    check("lk_e5_y", int'(bus.y), 2);

    // Same-cycle write and lookup of 0x82: write-first.
    set_idx(8'h82);
    bus.in_valid = 1'b1;
    write(8'h82, 3'd3, 1'b0);
    bus.in_valid = 1'b0;
    check("wf_valid", int'(bus.y_valid), 1);
    check("wf_y", int'(bus.y), 3);

    write(8'h08, 3'd1, 1'b0);
    @(negedge clk);
    check("idle_no_valid", int'(bus.y_valid), 0);
    check("idle_hold_y", int'(bus.y), 3);

    // Sweep with a lookup of 0xE5 accepted in the same cycle T.
    set_idx(8'hE5);
    bus.in_valid = 1'b1;
    bus.sweep_start = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sweep_start = 1'b0;
    check("t1_lookup_valid", int'(bus.y_valid), 1);
    check("t1_lookup_y", int'(bus.y), 2);
    check("t1_ready", int'(bus.ready), 0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check("sw_valid", int'(bus.y_valid), 1);
      check("sw_idx", int'(bus.sweep_idx), k);
      check("sw_y", int'(bus.y), sweep_lit(k));
      check("sw_done", int'(bus.sweep_done), (k == N - 1) ? 1 : 0);
      check("sw_ready", int'(bus.ready), (k == N - 1) ? 1 : 0);
    end
    @(negedge clk);
    check("post_sweep_valid", int'(bus.y_valid), 0);
    check("post_sweep_done", int'(bus.sweep_done), 0);

    // Reset in the middle of a sweep.
    bus.sweep_start = 1'b1;
    @(negedge clk);
    bus.sweep_start = 1'b0;
    n = 0;
    while (!(bus.y_valid && bus.sweep_idx == 8'd100) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx100", (n < 300) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", int'(bus.y_valid), 0);
    check("abort_done", int'(bus.sweep_done), 0);
    check("abort_ready", int'(bus.ready), 0);
    rst = 1'b0;
    count_clear("clear_len_abort");
    lookup(8'hE5);
    check("after_clear_valid", int'(bus.y_valid), 1);
    check("after_clear_y", int'(bus.y), 0);

`ifdef TT_PARITY_EN
    write(8'h10, 3'd5, 1'b1);
    lookup(8'h10);
    check("par_flip_y", int'(bus.y), 5);
    check("par_flip_err", int'(bus.parity_err), 1);
    write(8'h10, 3'd5, 1'b0);
    lookup(8'h10);
    check("par_ok_y", int'(bus.y), 5);
    check("par_ok_err", int'(bus.parity_err), 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_truthtable.md
Name: prog_truthtable

Overview:
- Programmable, registered successor to the fixed combinational truth table: the output y for every input combination {a, b, x} is held in a writable table, not hard-wired.
- Supports single lookups with a valid/ready handshake, run-time entry writes, a power-on clear sequence and a sequential sweep that streams every entry out for bench checking.
- Sits where the combinational truth-table block sat; lets labs and benches reprogram the function without re-synthesis.

Parameters:
- A_W, 3, width of input a
- B_W, 4, width of input b
- Y_W, 3, width of output y
- DEFAULT_Y, 0, value written to every entry during the clear sequence
- (derived) IW = A_W+B_W+1 is the index width; N = 2**IW is the entry count (256 at defaults).

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- a  in  A_W  lookup input a
- b  in  B_W  lookup input b
- x  in  1  lookup input x
- in_valid  in  1  lookup request
- ready  out  1  high when lookups and writes are accepted
- wr_en  in  1  table write strobe
- wr_addr  in  IW  entry index to write, ordered {a,b,x}
- wr_data  in  Y_W  entry value
- sweep_start  in  1  start full-table sweep
- y  out  Y_W  lookup or sweep result
- y_valid  out  1  y valid this cycle
- sweep_idx  out  IW  index of the entry currently on y during a sweep
- sweep_done  out  1  one-cycle pulse on the last sweep entry

Behaviour:
- Index = {a, b, x}; x is the LSB.
- States are CLEAR, IDLE and SWEEP. ready = (state == IDLE), registered.
- Reset (rst=1 at an edge): next state is CLEAR, clear counter is 0, y=0, y_valid=0, sweep_idx=0, sweep_done=0, ready=0. A reset mid-CLEAR restarts the clear at 0. A reset mid-SWEEP aborts the sweep, and no sweep_done is pulsed.
- CLEAR: writes DEFAULT_Y to one entry per cycle, index 0..N-1, then goes to IDLE. Lasts exactly N cycles after rst falls. wr_en, in_valid and sweep_start are ignored.
- IDLE lookup: if in_valid is sampled with ready=1, y shows the table entry and y_valid=1 on the next cycle (latency 1). Otherwise y_valid=0 and y holds its last value.
- IDLE write: if wr_en is sampled with ready=1, the entry is updated at that edge. A same-cycle lookup of the same index returns the new wr_data (write-first).
- SWEEP: sweep_start sampled in IDLE moves the state to SWEEP on the next cycle.
  - With sweep_start at cycle T, entry k appears on y with y_valid=1 and sweep_idx=k at cycle T+2+k.
  - sweep_done=1 coincides with entry N-1 at T+1+N.
  - State returns to IDLE at T+1+N.
  - A lookup accepted in the same cycle as sweep_start is served at T+1, so it does not collide with the sweep output.
- In SWEEP, lookups and writes are ignored (ready=0) and sweep_start is ignored.
- The table itself is not reset except through the CLEAR sequence.

Optional Feature:
- Macro: TT_PARITY_EN.
- When defined:
  - each entry stores an extra even-parity bit computed from wr_data (DEFAULT_Y during CLEAR);
  - extra input wr_par_flip (1 bit) inverts the stored parity bit on a write;
  - extra output parity_err (1 bit) is high with y_valid when the read parity mismatches; otherwise parity_err=0, and its reset value is 0.
- When undefined: no parity storage and no wr_par_flip or parity_err ports.

Decomposition:
- Package tt_pkg holds the state enum (CLEAR, IDLE, SWEEP) and a parity helper function.
- Sub-module tt_mem: N x Y_W (+1 with parity) storage, one write port, one registered read port, write-first on same-address collision.
- FSM, counter and handshake logic live in prog_truthtable.

Test Plan:
- Release rst: ready stays 0 for 256 cycles, then goes to 1. Lookup a=7, b=2, x=1 then returns y=0 with y_valid one cycle later.
- Write wr_addr=0xE5 ({111,0010,1}), wr_data=2. Lookup a=7, b=2, x=1 on the next cycle: y=2, y_valid=1 one cycle after the request.
- Same-cycle write and lookup at index 0x82 (a=4, b=1, x=0) with wr_data=3: y=3 on the next cycle.
- Write 0x08=1 (a=0, b=4, x=0), then sweep_start at T:
  - y_valid=1 for cycles T+2..T+257;
  - sweep_idx 0x08 shows y=1, 0xE5 shows y=2, 0x82 shows y=3, all other entries show y=0;
  - sweep_done only at T+257;
  - ready=1 again at T+257.
- Assert rst while sweep_idx=100: y_valid=0 the following cycle, no sweep_done, 256-cycle CLEAR, after which a lookup of 0xE5 returns y=0.
- With TT_PARITY_EN: write 0x10=5 with wr_par_flip=1, then lookup: y=5 with parity_err=1. Rewrite with wr_par_flip=0, then lookup: parity_err=0.
